inst_fetcher: RTL and testbench

//   Instruction-fetch stage ahead of the decoder. Holds the architectural fetch PC.

---
 rtl/inst_fetcher.sv | 164 ++++++++++++++++
 tb/tb_inst_fetcher.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
`default_nettype none
// =============================================================================
// Module  : inst_fetcher
// Purpose : Fetch PC plus byte-serial instruction fetch into a direct-mapped
//           I-cache (macro INST_FETCHER_ICACHE_EN) or a single tagged word buffer.
// Revision: 1.0 - initial release
// =============================================================================
module inst_fetcher #(
    parameter int          IDX_W    = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        issue,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_din,
    output logic        hit,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    if (IDX_W < 1 || IDX_W > 29) begin : g_idx_check
        $error("inst_fetcher: IDX_W out of range");
    end

    state_t      r_state;
    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic [23:0] r_buf;
    logic        r_mem_req;

    logic        w_present;
    logic [31:0] w_stored;
    logic        w_hit;
    logic        w_advance;
    logic        w_fill;
    logic [31:0] w_word;

    assign w_word    = {mem_din, r_buf};
    assign w_hit     = w_present && (r_state == S_IDLE) && !jump_en;
    assign w_advance = rdy && issue && w_hit;
    // The last byte completes a line only when no redirect claims the same cycle
    assign w_fill    = !rst && rdy && !jump_en && (r_state == S_FETCH)
                       && mem_ready && (r_cnt == 2'd3);

    assign hit      = w_hit;
    assign pc_out   = r_pc;
    assign inst_out = w_stored;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_pc + {30'd0, r_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_cnt     <= 2'd0;
            r_buf     <= 24'd0;
            r_mem_req <= 1'b0;
        end else if (rdy) begin
            if (jump_en) begin
                r_pc      <= jump_addr;
                r_state   <= S_IDLE;
                r_cnt     <= 2'd0;
                r_mem_req <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_hit) begin
                            if (issue) begin
                                r_pc <= r_pc + 32'd4;
                            end
                        end else begin
                            r_state   <= S_FETCH;
                            r_cnt     <= 2'd0;
                            r_mem_req <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (mem_ready) begin
                            case (r_cnt)
                                2'd0:    r_buf[7:0]   <= mem_din;
                                2'd1:    r_buf[15:8]  <= mem_din;
                                2'd2:    r_buf[23:16] <= mem_din;
                                default: ;
                            endcase
                            r_cnt <= r_cnt + 2'd1;
                            if (r_cnt == 2'd3) begin
                                r_state   <= S_IDLE;
                                r_mem_req <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef INST_FETCHER_ICACHE_EN
    localparam int C_LINES = 2 ** IDX_W;
    localparam int C_TAG_W = 32 - IDX_W - 2;

    logic [C_LINES-1:0] r_valid;
    logic [C_TAG_W-1:0] r_tag  [C_LINES];
    logic [31:0]        r_data [C_LINES];
    logic [IDX_W-1:0]   w_line;
    logic [C_TAG_W-1:0] w_tag;

    assign w_line    = r_pc[IDX_W+1:2];
    assign w_tag     = r_pc[31:IDX_W+2];
    assign w_present = r_valid[w_line] && (r_tag[w_line] == w_tag);
    // Invalid lines present zero so inst_out reads 0 straight out of reset
    assign w_stored  = r_valid[w_line] ? r_data[w_line] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_line] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_line]  <= w_tag;
            r_data[w_line] <= w_word;
        end
    end
`else
    logic        r_bvalid;
    logic [31:0] r_bpc;
    logic [31:0] r_binst;

    assign w_present = r_bvalid && (r_bpc == r_pc);
    assign w_stored  = r_binst;

    // Consuming the buffered word retires it, so the next PC always refetches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bpc    <= RESET_PC;
            r_binst  <= 32'h0;
        end else if (w_fill) begin
            r_bvalid <= 1'b1;
            r_bpc    <= r_pc;
            r_binst  <= w_word;
        end else if (w_advance) begin
            r_bvalid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// =============================================================================
// Module  : tb_inst_fetcher
// Purpose : Directed timing checks plus randomized scoreboard run for inst_fetcher.
// Revision: 1.0 - initial release
// =============================================================================
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst, rdy, issue, jump_en, mem_ready;
    logic [31:0] jump_addr;
    logic        mem_req, hit;
    logic [31:0] mem_addr, pc_out, inst_out;
    logic [7:0]  mem_din;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          n_consumed = 0;
    logic [31:0] m_pc       = 32'h0;
    bit          mon_en     = 1'b0;
    bit          drv_done   = 1'b0;

    always #5 clk = ~clk;

    inst_fetcher #(.IDX_W(7), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .issue(issue),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_din(mem_din),
        .hit(hit), .pc_out(pc_out), .inst_out(inst_out)
    );

    // Instruction memory contents: the cold-miss word at 0, a byte hash elsewhere
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h00;
            32'd2:   return 8'h50;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {byte_at(pc + 32'd3), byte_at(pc + 32'd2), byte_at(pc + 32'd1), byte_at(pc)};
    endfunction

    assign mem_din = byte_at(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            if (hit) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = word_at(pc);
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom % 4)
            0:       return 32'($urandom_range(0, 15)) << 2;
            1:       return 32'h200 + (32'($urandom_range(0, 3)) << 2);
            2:       return $urandom() & 32'hFFFF_FFFC;
            default: return 32'hFFFF_FFF8;
        endcase
    endfunction

    task automatic monitor();
        while (!drv_done) begin
            @(negedge clk);
            if (mon_en) begin
                if (hit) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_empty: hit presented pc_out=%h with no expected entry", pc_out);
                    end else begin
                        check("sb_pc", pc_out, exp_q[0].pc);
                        check("sb_inst", inst_out, exp_q[0].inst);
                        if (rdy && issue) begin
                            void'(exp_q.pop_front());
                            n_consumed++;
                        end
                    end
                end
                if (rdy && mem_req && mem_ready && !jump_en)
                    check("bus_addr", {2'b00, mem_addr[31:2]}, {2'b00, m_pc[31:2]});
            end
        end
    endtask

    task automatic driver();
        int seen;
        seen   = n_consumed;
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (n_consumed != seen) begin
                seen = n_consumed;
                m_pc = m_pc + 32'd4;
                push_exp(m_pc);
            end
            rdy       = (c == 0) || (($urandom % 8) != 0);
            issue     = $urandom % 2;
            mem_ready = ($urandom % 4) != 0;
            jump_en   = (c == 0) || (($urandom % 20) == 0);
            jump_addr = pick_target();
            if (rdy && jump_en) begin
                exp_q.delete();
                m_pc = jump_addr;
                push_exp(m_pc);
            end
            cyc();
        end
        rdy     = 1'b1;
        issue   = 1'b0;
        jump_en = 1'b0;
        mon_en  = 1'b0;
        check("progress", (n_consumed >= 20) ? 32'd1 : 32'd0, 32'd1);
        drv_done = 1'b1;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; rdy = 1'b1; issue = 1'b0; jump_en = 1'b0;
        jump_addr = 32'h0; mem_ready = 1'b0;
        cyc();
        cyc();

        // Reset state
        rst = 1'b0;
        #1;
        check("reset_hit", {31'd0, hit}, 32'd0);
        check("reset_req", {31'd0, mem_req}, 32'd0);
        check("reset_pc", pc_out, 32'h0);
        check("reset_inst", inst_out, 32'h0);

        // Cold miss at 0
        mem_ready = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cold_req", {31'd0, mem_req}, 32'd1);
            check("cold_addr", mem_addr, 32'(k));
            cyc();
        end
        #1;
        check("cold_hit", {31'd0, hit}, 32'd1);
        check("cold_inst", inst_out, 32'h0050_0013);
        check("cold_pc", pc_out, 32'h0);
        check("cold_req_drop", {31'd0, mem_req}, 32'd0);

        // Issue advances to 4 and starts the next fetch
        issue = 1'b1;
        cyc();
        issue = 1'b0;
        #1;
        check("issue_pc", pc_out, 32'h4);
        check("issue_hit", {31'd0, hit}, 32'd0);
        check("issue_addr", mem_addr, 32'h4);
        cyc();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fetch4_req", {31'd0, mem_req}, 32'd1);
            check("fetch4_addr", mem_addr, 32'h4 + 32'(k));
            cyc();
        end
        #1;
        check("fetch4_hit", {31'd0, hit}, 32'd1);
        check("fetch4_inst", inst_out, word_at(32'h4));

        // Jump back to 0
        jump_en = 1'b1; jump_addr = 32'h0;
        #1;
        check("jump_hit_forced", {31'd0, hit}, 32'd0);
        cyc();
        jump_en = 1'b0;
`ifdef INST_FETCHER_ICACHE_EN
        #1;
        check("rehit_hit", {31'd0, hit}, 32'd1);
        check("rehit_req", {31'd0, mem_req}, 32'd0);
        check("rehit_inst", inst_out, 32'h0050_0013);
`else
        #1;
        check("refetch_miss", {31'd0, hit}, 32'd0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("refetch_addr", mem_addr, 32'(k));
            cyc();
        end
        #1;
        check("refetch_hit", {31'd0, hit}, 32'd1);
        check("refetch_inst", inst_out, 32'h0050_0013);
`endif

        // Abort a fetch after two bytes
        jump_en = 1'b1; jump_addr = 32'h40;
        cyc();
        jump_en = 1'b0;
        cyc();
        cyc();
        cyc();
        jump_en = 1'b1; jump_addr = 32'h100;
        #1;
        check("abort_pre_addr", mem_addr, 32'h42);
        cyc();
        jump_addr = 32'h40;
        #1;
        check("abort_addr", mem_addr, 32'h100);
        check("abort_req", {31'd0, mem_req}, 32'd0);
        check("abort_pc", pc_out, 32'h100);
        cyc();
        jump_en = 1'b0;
        #1;
        check("abort_not_written", {31'd0, hit}, 32'd0);

        // Stall three cycles mid-fetch
        cyc();
        cyc();
        cyc();
        rdy = 1'b0; issue = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_addr", mem_addr, 32'h42);
            check("stall_req", {31'd0, mem_req}, 32'd1);
            check("stall_hit", {31'd0, hit}, 32'd0);
            cyc();
        end
        rdy = 1'b1; issue = 1'b0;
        #1;
        check("stall_resume_addr", mem_addr, 32'h42);
        cyc();
        cyc();
        #1;
        check("stall_hit_after", {31'd0, hit}, 32'd1);
        check("stall_inst", inst_out, word_at(32'h40));

        // Conflict: 0x200 shares line 0 and evicts it
        jump_en = 1'b1; jump_addr = 32'h200;
        cyc();
        jump_en = 1'b0;
        wait_hit(20, ok);
        check("conflict_wait", {31'd0, ok}, 32'd1);
        check("conflict_inst", inst_out, word_at(32'h200));
        check("conflict_pc", pc_out, 32'h200);
        jump_en = 1'b1; jump_addr = 32'h0;
        cyc();
        jump_en = 1'b0;
        #1;
        check("conflict_evicted", {31'd0, hit}, 32'd0);
        cyc();

        // Randomized run against the scoreboard
        fork
            monitor();
            driver();
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
